// File: rtl/four_bit_mc_df_pkg.sv
// Shared types for the magnitude comparator: result enum, one-hot flag payload and conversion helper.
package mc_pkg;

   localparam int unsigned MC_DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {MC_LT, MC_EQ, MC_GT} mc_result_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } mc_flags_t;

   // Expand a compare result into its one-hot flag triple.
   function automatic mc_flags_t mc_to_flags(input mc_result_t r);
      mc_flags_t f;
      f.gt = (r == MC_GT);
      f.eq = (r == MC_EQ);
      f.lt = (r == MC_LT);
      return f;
   endfunction

endpackage

// File: rtl/four_bit_mc_df_if.sv
// Operand/result bundle for four_bit_mc_df; cascade inputs exist only when MC_CASCADE_EN is defined.
interface four_bit_mc_df_if
   import mc_pkg::*;
#(
   parameter int unsigned WIDTH = MC_DEFAULT_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef MC_CASCADE_EN
   logic             gt_in;
   logic             eq_in;
   logic             lt_in;
`endif
   logic             out_valid;
   logic             a_gt_b;
   logic             a_eq_b;
   logic             a_lt_b;

`ifdef MC_CASCADE_EN
   modport master (output in_valid, a, b, gt_in, eq_in, lt_in,
                   input  out_valid, a_gt_b, a_eq_b, a_lt_b);
   modport slave  (input  in_valid, a, b, gt_in, eq_in, lt_in,
                   output out_valid, a_gt_b, a_eq_b, a_lt_b);
`else
   modport master (output in_valid, a, b,
                   input  out_valid, a_gt_b, a_eq_b, a_lt_b);
   modport slave  (input  in_valid, a, b,
                   output out_valid, a_gt_b, a_eq_b, a_lt_b);
`endif

endinterface

// File: rtl/four_bit_mc_df_core.sv
// Combinational unsigned comparator; with MC_CASCADE_EN, equal operands defer to the cascade inputs.
module mc_core
   import mc_pkg::*;
#(
   parameter int unsigned WIDTH = MC_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
`ifdef MC_CASCADE_EN
   input  logic             i_gt_in,
   input  logic             i_eq_in,
   input  logic             i_lt_in,
`endif
   output mc_result_t       o_result
);

   mc_result_t w_local;

   assign w_local = (i_a > i_b) ? MC_GT : ((i_a < i_b) ? MC_LT : MC_EQ);

`ifdef MC_CASCADE_EN
   mc_result_t w_casc;

   // eq_in outranks gt_in outranks lt_in; nothing asserted reads as equal.
   assign w_casc   = i_eq_in ? MC_EQ : (i_gt_in ? MC_GT : (i_lt_in ? MC_LT : MC_EQ));
   assign o_result = (w_local == MC_EQ) ? w_casc : w_local;
`else
   assign o_result = w_local;
`endif

endmodule

// File: rtl/four_bit_mc_df.sv
// Registered magnitude comparator top: qualifies inputs, registers flags and valid. Optional MC_CASCADE_EN.
module four_bit_mc_df
   import mc_pkg::*;
#(
   parameter int unsigned WIDTH = MC_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   four_bit_mc_df_if.slave  bus
);

   mc_result_t w_result;
   mc_flags_t  r_flags;
   logic       r_valid;

   mc_core #(.WIDTH(WIDTH)) u_core (
      .i_a      (bus.a),
      .i_b      (bus.b),
`ifdef MC_CASCADE_EN
      .i_gt_in  (bus.gt_in),
      .i_eq_in  (bus.eq_in),
      .i_lt_in  (bus.lt_in),
`endif
      .o_result (w_result)
   );

   // Flags only update on a valid input so they hold through idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_flags <= '0;
      end else begin
         r_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_flags <= mc_to_flags(w_result);
         end
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.a_gt_b    = r_flags.gt;
   assign bus.a_eq_b    = r_flags.eq;
   assign bus.a_lt_b    = r_flags.lt;

endmodule

// File: tb/tb_four_bit_mc_df.sv
// Scoreboard bench for four_bit_mc_df; cascade cases compile in when MC_CASCADE_EN is defined.
module tb_four_bit_mc_df;

   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [2:0] sb[$];

   always #5 clk = ~clk;

   four_bit_mc_df_if #(.WIDTH(W)) bus ();

   four_bit_mc_df #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference: flags as {gt,eq,lt}, from plain integer comparison.
   function automatic logic [2:0] model(input int ia, input int ib, input logic [2:0] casc);
      if (ia > ib) return 3'b100;
      if (ia < ib) return 3'b001;
`ifdef MC_CASCADE_EN
      if (casc[1]) return 3'b010;
      if (casc[2]) return 3'b100;
      if (casc[0]) return 3'b001;
`else
      if (casc == 3'b111) return 3'b010;
`endif
      return 3'b010;
   endfunction

   function automatic logic [2:0] flags();
      return {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   // casc is {gt_in, eq_in, lt_in}
   task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic r, input logic [2:0] casc);
      @(posedge clk);
      #1;
      rst          = r;
      bus.in_valid = v;
      bus.a        = ta;
      bus.b        = tb_;
`ifdef MC_CASCADE_EN
      {bus.gt_in, bus.eq_in, bus.lt_in} = casc;
`endif
      if (v && !r) sb.push_back(model(int'(ta), int'(tb_), casc));
   endtask

   // Monitor: every presented output must match the oldest expected result and be one-hot.
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 4'd1, 4'd0);
         end else begin
            logic [2:0] e;
            e = sb.pop_front();
            check("flags", {1'b0, flags()}, {1'b0, e});
            check("one_hot", 4'($countones(flags())), 4'd1);
         end
      end
   end

   initial begin
      logic [W-1:0] ones;
      ones         = '1;
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.a        = 4'd8;
      bus.b        = 4'd3;
`ifdef MC_CASCADE_EN
      {bus.gt_in, bus.eq_in, bus.lt_in} = 3'b010;
`endif
      // Reset held with in_valid high: everything stays cleared.
      repeat (2) begin
         @(negedge clk);
         check("reset", {bus.out_valid, flags()}, 4'b0000);
      end

      // Directed rows and corners
      drive(1, 4'd8,  4'd3, 0, 3'b010);
      drive(1, 4'd1,  4'd0, 0, 3'b010);
      drive(1, 4'd9,  4'd9, 0, 3'b010);
      drive(1, 4'd5,  4'd7, 0, 3'b010);
      drive(1, 4'd15, 4'd4, 0, 3'b010);
      drive(1, 4'd0,  4'd0, 0, 3'b010);
      drive(1, ones,  4'd0, 0, 3'b010);
      drive(1, 4'd0,  ones, 0, 3'b010);

      // Exhaustive back-to-back sweep
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            drive(1, W'(i), W'(j), 0, 3'b010);

      // Hold: flags stay lt while idle, even as operands change.
      drive(1, 4'd5, 4'd7, 0, 3'b010);
      drive(0, 4'd0, 4'd0, 0, 3'b010);
      @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         check("hold", {bus.out_valid, flags()}, 4'b0001);
      end

      // Reset wins over a simultaneous valid input.
      drive(1, 4'd8, 4'd3, 0, 3'b010);
      drive(1, 4'd0, 4'd15, 1, 3'b010);
      @(negedge clk);
      @(negedge clk);
      check("reset_precedence", {bus.out_valid, flags()}, 4'b0000);

`ifdef MC_CASCADE_EN
      drive(1, 4'd6, 4'd6, 0, 3'b100);
      drive(1, 4'd6, 4'd6, 0, 3'b010);
      drive(1, 4'd2, 4'd6, 0, 3'b100);
      drive(1, 4'd6, 4'd6, 0, 3'b001);
      drive(1, 4'd6, 4'd6, 0, 3'b000);
`endif

      // Randomized traffic with gaps, cascade inputs and occasional reset.
      for (int k = 0; k < 400; k++)
         drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
               $urandom_range(0, 24) == 0, 3'($urandom));

      drive(0, 4'd0, 4'd0, 0, 3'b010);
      for (int k = 0; k < 8 && sb.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      check("drain", 4'(sb.size()), 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
